// File: rtl/multi_clock_gen.sv
// Multi-channel programmable clock/tick generator: each channel divides clk by a
// runtime divisor, producing a one-cycle tick and a 50%-duty divided clock.

module mcg_lane #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdiv,
  output logic             tick,
  output logic             clk_o
);
  logic [CNT_W-1:0] cnt, div_act, div_shd;
  logic             shd_pend;
  logic             wrap;

  assign wrap = (cnt == div_act - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= CNT_W'(DEFAULT_DIV);
      div_shd  <= CNT_W'(DEFAULT_DIV);
      shd_pend <= 1'b0;
      tick     <= 1'b0;
      clk_o    <= 1'b0;
    end else begin
      if (clr || !en) begin
        cnt   <= '0;
        tick  <= 1'b0;
        clk_o <= 1'b0;
        if (shd_pend) begin
          div_act  <= div_shd;
          shd_pend <= 1'b0;
        end
      end else if (wrap) begin
        cnt   <= '0;
        tick  <= 1'b1;
        clk_o <= ~clk_o;
        if (shd_pend) begin
          div_act  <= div_shd;
          shd_pend <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A same-edge write lands after any shadow transfer above, so it stays pending.
      if (wr) begin
        div_shd  <= wdiv;
        shd_pend <= 1'b1;
      end
    end
  end
endmodule

module multi_clock_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 32,
  parameter  int DEFAULT_DIV = 250000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_o
);
  logic wr_ok;

  assign wr_ok = cfg_we && (cfg_div != '0) && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= wr_ok;
      cfg_err <= cfg_we && !wr_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    mcg_lane #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[g]),
      .clr   (sync_clr),
      .wr    (wr_ok && (cfg_ch == CH_W'(g))),
      .wdiv  (cfg_div),
      .tick  (tick_o[g]),
      .clk_o (clk_o[g])
    );
  end
endmodule

// File: tb/tb_multi_clock_gen.sv
// Randomized bench for multi_clock_gen against a cycle-count reference model.
// Three channels on a 2-bit channel index so out-of-range writes are reachable.

module tb_multi_clock_gen;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DDIV   = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync_clr, cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_ack, cfg_err;
  logic [NUM_CH-1:0] tick_o, clk_o;

  int checks = 0;
  int errors = 0;

  // Model: elapsed enabled cycles in the current period, active/pending divisors.
  int age [NUM_CH];
  int adiv[NUM_CH];
  int pdiv[NUM_CH];
  bit pend[NUM_CH];
  logic [NUM_CH-1:0] m_tick, m_clk;
  logic m_ack, m_err;

  multi_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .tick_o(tick_o), .clk_o(clk_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      age[i] = 0; adiv[i] = DDIV; pdiv[i] = DDIV; pend[i] = 0;
    end
    m_tick = '0; m_clk = '0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ok;
    ok = cfg_we && cfg_div != 0 && int'(cfg_ch) < NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_clr || !en[i]) begin
        age[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        if (pend[i]) begin adiv[i] = pdiv[i]; pend[i] = 0; end
      end else begin
        age[i]++;
        if (age[i] == adiv[i]) begin
          age[i] = 0; m_tick[i] = 1; m_clk[i] = ~m_clk[i];
          if (pend[i]) begin adiv[i] = pdiv[i]; pend[i] = 0; end
        end else m_tick[i] = 0;
      end
    end
    if (ok) begin pdiv[cfg_ch] = int'(cfg_div); pend[cfg_ch] = 1; end
    m_ack = ok;
    m_err = cfg_we && !ok;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"}, 32'(tick_o), 32'(m_tick));
    chk({tag, ".clko"}, 32'(clk_o), 32'(m_clk));
    chk({tag, ".ack"}, 32'(cfg_ack), 32'(m_ack));
    chk({tag, ".err"}, 32'(cfg_err), 32'(m_err));
  endtask

  task automatic randomize_inputs(input int mode);
    for (int i = 0; i < NUM_CH; i++)
      if ($urandom_range(0, 40) == 0) en[i] = ~en[i];
    sync_clr = ($urandom_range(0, 60) == 0);
    cfg_we   = ($urandom_range(0, mode) == 0);
    cfg_ch   = CH_W'($urandom_range(0, 3));
    cfg_div  = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 9));
  endtask

  initial begin
    rst_n = 1'b0; en = '1; sync_clr = 0; cfg_we = 0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    // Plain default-rate run: tick every 4 cycles, clk_o period 8.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); model_step(); #1; check_all("default");
    end
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); model_step(); #1; check_all("rand");
      if (c == 1500 || c == 2700) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        #1 rst_n = 1'b1;
      end
      randomize_inputs((c < 2000) ? 3 : 12);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
